// File: rtl/joy_pkg.sv
// Shared definitions for the joystick serial-port responder: button bit
// positions, FSM state encoding and the on-the-wire word format.
package joy_pkg;

  localparam int JOY_WIDTH = 16;

  localparam int JOY_UP    = 7;
  localparam int JOY_DOWN  = 6;
  localparam int JOY_LEFT  = 5;
  localparam int JOY_RIGHT = 4;
  localparam int JOY_FIRE1 = 3;
  localparam int JOY_FIRE2 = 2;
  localparam int JOY_FIRE3 = 1;
  localparam int JOY_START = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADING  = 2'd1,
    ST_SHIFTING = 2'd2
  } joy_state_e;

  // Buttons are 1 = pressed; the 74HC165 chain presents them active-low,
  // joy1 up in the MSB so it is the first bit the host sees.
  function automatic logic [15:0] joy_wire_word(input logic [7:0] j1,
                                                input logic [7:0] j2);
    return ~{j1, j2};
  endfunction

endpackage

// File: rtl/joy_shifter_responder_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, with a history flop that
// turns the synchronised level into single-cycle rise/fall pulses.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/joy_shifter_responder.sv
// Device side of the joystick LOAD/CLK/DATA port: emulates two cascaded
// 74HC165s, clocked from a system clk at least 4x the host shift rate.
module joy_shifter_responder
  import joy_pkg::*;
#(
  parameter int WIDTH       = JOY_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       joy_clk,
  input  logic       joy_load_n,
  output logic       joy_data,
  input  logic [7:0] joy1_btn,
  input  logic [7:0] joy2_btn,
  input  logic       serial_in,
  output logic       frame_done,
  output logic       frame_abort,
  output logic [4:0] bit_count
);

  localparam int TMO_W = $clog2(TIMEOUT);

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    if (v >= 5'(WIDTH)) return 5'(WIDTH);
    return v + 5'd1;
  endfunction

  logic clk_level, clk_rise, clk_fall;
  logic load_s, load_rise, load_fall;
  logic unused_sync;

  joy_state_e        state, state_nxt;
  logic [WIDTH-1:0]  shreg;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [15:0]       wire_word;
  logic              tmo_hit, frame_full, do_load, do_shift;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clk (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (joy_clk),
    .level    (clk_level),
    .rise     (clk_rise),
    .fall     (clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_load (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (joy_load_n),
    .level    (load_s),
    .rise     (load_rise),
    .fall     (load_fall)
  );

  assign unused_sync = ^{clk_level, clk_fall, load_rise, load_fall};

  assign wire_word  = joy_wire_word(joy1_btn, joy2_btn);
  // The host reads bit 0 without a trailing clock, so WIDTH-1 shifts is a full frame.
  assign frame_full = (bit_count >= 5'(WIDTH - 1));
  // A host edge arriving in the timeout cycle keeps the frame alive.
  assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT - 1)) && !clk_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (!load_s) state_nxt = ST_LOADING;
      ST_LOADING:  if (load_s)  state_nxt = ST_SHIFTING;
      ST_SHIFTING: begin
        if (!load_s)      state_nxt = ST_LOADING;
        else if (tmo_hit) state_nxt = ST_IDLE;
      end
      default:            state_nxt = ST_IDLE;
    endcase
  end

  // Load has priority over a coincident shift edge.
  always_comb begin
    do_load     = 1'b0;
    do_shift    = 1'b0;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    case (state)
      ST_LOADING: do_load = 1'b1;
      ST_SHIFTING: begin
        if (!load_s) begin
          frame_done  = frame_full;
          frame_abort = !frame_full;
        end else begin
          do_shift    = clk_rise;
          frame_abort = tmo_hit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '1;
      bit_count <= '0;
      tmo_cnt   <= '0;
    end else begin
      if (do_load) begin
        shreg     <= wire_word[15 -: WIDTH];
        bit_count <= '0;
      end else if (do_shift) begin
        shreg     <= {shreg[WIDTH-2:0], serial_in};
        bit_count <= sat_inc(bit_count);
      end
      if (state_nxt != ST_SHIFTING || do_shift) tmo_cnt <= '0;
      else                                      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign joy_data = shreg[WIDTH-1];

endmodule

// File: tb/tb_joy_shifter_responder.sv
// Randomised bench for joy_shifter_responder acting as a host: loads frames,
// clocks bits out and compares against a queue-based model of the chain.
module tb_joy_shifter_responder;
  import joy_pkg::*;

  localparam int WIDTH       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       joy_clk = 1'b0;
  logic       joy_load_n = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] joy1_btn = 8'h00;
  logic [7:0] joy2_btn = 8'h00;
  logic       joy_data, frame_done, frame_abort;
  logic [4:0] bit_count;

  always #5 clk = ~clk;

  joy_shifter_responder #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .joy_clk     (joy_clk),
    .joy_load_n  (joy_load_n),
    .joy_data    (joy_data),
    .joy1_btn    (joy1_btn),
    .joy2_btn    (joy2_btn),
    .serial_in   (serial_in),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .bit_count   (bit_count)
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, abort_cnt = 0, both_cnt = 0;
  int last_abort_cyc = -1, last_rise_cyc = 0;

  // Reference model: bits still to be presented, shifts since load, frame open.
  bit q[$];
  int shifts = 0;
  bit in_frame = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_abort) begin abort_cnt++; last_abort_cyc = cyc; end
    if (frame_done && frame_abort) both_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int sat(input int v);
    return (v > WIDTH) ? WIDTH : v;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < WIDTH; i++) q.push_back(1'b1);
    shifts   = 0;
    in_frame = 1'b0;
  endtask

  task automatic read_check(input string tag);
    check_val({tag, "_data"}, joy_data, q[0]);
    check_val({tag, "_cnt"}, bit_count, sat(shifts));
  endtask

  // Pulse load_n low for 10 clk; with coll=1 joy_clk rises on the same edge.
  task automatic start_frame(input logic [7:0] j1, input logic [7:0] j2, input bit coll);
    int d0, a0;
    bit exp_done, exp_abort;
    logic [15:0] w;
    exp_done  = in_frame && (shifts >= WIDTH - 1);
    exp_abort = in_frame && !exp_done;
    d0 = done_cnt;
    a0 = abort_cnt;
    joy1_btn   = j1;
    joy2_btn   = j2;
    joy_load_n = 1'b0;
    if (coll) begin
      joy_clk = 1'b1;
      tick(SYNC_STAGES + 1);
      check_val("coll_noshift", joy_data, q[0]);
      check_val("coll_cnt", bit_count, sat(shifts));
      tick(10 - SYNC_STAGES - 1);
      joy_clk = 1'b0;
    end else begin
      tick(10);
    end
    check_val("done_evt", done_cnt - d0, exp_done);
    check_val("abort_evt", abort_cnt - a0, exp_abort);
    joy_load_n = 1'b1;
    tick(4);
    w = ~{j1, j2};
    q.delete();
    for (int i = WIDTH - 1; i >= 0; i--) q.push_back(w[i]);
    shifts   = 0;
    in_frame = 1'b1;
    read_check("load");
  endtask

  // One joy_clk period of 8 clk; the model only shifts while a frame is open.
  task automatic pulse(input bit sin);
    serial_in     = sin;
    joy_clk       = 1'b1;
    last_rise_cyc = cyc;
    tick(4);
    joy_clk = 1'b0;
    tick(4);
    if (in_frame) begin
      void'(q.pop_front());
      q.push_back(sin);
      shifts++;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b1, b2;
    int a0, d0, n;

    #1 rst_n = 1'b0;
    #11;
    check_val("rst_data", joy_data, 1);
    check_val("rst_cnt", bit_count, 0);
    check_val("rst_done", frame_done, 0);
    check_val("rst_abort", frame_abort, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    model_reset();

    // Basic frame: joy1 up, joy2 start
    start_frame(8'(1 << JOY_UP), 8'(1 << JOY_START), 1'b0);
    for (int i = 0; i < WIDTH - 1; i++) begin pulse(1'b1); read_check("basic"); end

    // Short frame
    start_frame(8'h5A, 8'hC3, 1'b0);
    for (int i = 0; i < 5; i++) begin pulse(1'b1); read_check("short"); end
    start_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);

    // Overrun with serial_in = 0
    for (int i = 0; i < 20; i++) begin pulse(1'b0); read_check("overrun"); end
    serial_in = 1'b1;

    // Collision: the bit after six shifts differs from the one after seven
    start_frame(8'h02, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 6; i++) begin pulse(1'b1); read_check("precoll"); end
    start_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);

    // Buttons change mid-frame; the new value only shows after the next load
    for (int i = 0; i < 4; i++) begin pulse(1'b1); read_check("mid_a"); end
    b1 = ~joy1_btn;
    b2 = 8'($urandom_range(0, 255));
    joy1_btn = b1;
    joy2_btn = b2;
    for (int i = 0; i < WIDTH - 5; i++) begin pulse(1'b1); read_check("mid_b"); end
    start_frame(b1, b2, 1'b0);
    for (int i = 0; i < WIDTH - 1; i++) begin pulse(1'b1); read_check("mid_new"); end

    // Timeout after three clocks
    start_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 3; i++) begin pulse(1'b1); read_check("tmo_pre"); end
    a0 = abort_cnt;
    d0 = done_cnt;
    for (int i = 0; i < TIMEOUT + 64 && abort_cnt == a0; i++) tick(1);
    tick(2);
    check_val("tmo_evt", abort_cnt - a0, 1);
    check_val("tmo_done", done_cnt - d0, 0);
    check_val("tmo_time", last_abort_cyc, last_rise_cyc + SYNC_STAGES + TIMEOUT);
    in_frame = 1'b0;
    read_check("tmo_hold");
    pulse(1'b0);
    read_check("tmo_idle");

    // Reset mid-frame after seven shifts
    start_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 7; i++) begin pulse(1'b1); read_check("prerst"); end
    rst_n = 1'b0;
    #1;
    model_reset();
    read_check("rst_mid");
    check_val("rst_mid_abort", frame_abort, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    pulse(1'b0);
    read_check("rst_idle");
    start_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < WIDTH - 1; i++) begin pulse(1'b1); read_check("fresh"); end

    // Random frames of random length and cascade data
    for (int f = 0; f < 25; f++) begin
      start_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) begin
        pulse(1'($urandom_range(0, 1)));
        read_check("rand");
      end
    end
    start_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);

    check_val("done_abort_excl", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
